collect_rx: RTL and testbench

- Receive-side counterpart of the dispatch stage.
- Accepts scrambled, order-tagged beats and descrambles them with the same key table.
- Checks that order IDs arrive in strict sequence. On a gap, pulses `tail_o` back to the dispatcher to request a resend, then discards beats until the expected ID reappears.
- Delivers an in-order, descrambled stream downstream.

---
 rtl/collect_rx.sv | 140 ++++++++++++++
 tb/tb_collect_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/collect_rx.sv
// collect_rx: receive-side collector. Descrambles order-tagged beats,
// enforces strict ID sequence, requests resends on gaps.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   vld_i        input beat valid
//   data_i       scrambled payload
//   key_index_i  key select (0..2 -> KEY, 3..7 -> pass-through)
//   order_id_i   order tag of the input beat
//   vld_o        output beat valid (1 cycle after accept)
//   data_o       descrambled payload, held when vld_o=0
//   id_o         order tag of the output beat, held when vld_o=0
//   tail_o       single-cycle resend request to the dispatcher
//   resync_o     high while waiting for the expected ID to reappear
//   err_cnt_o    saturating count of sequence errors seen in RUN
module collect_rx #(
    parameter int              DW      = 32,
    parameter int              IDW     = 4,
    parameter logic [DW-1:0]   KEY     = DW'(32'h0000_FFFF),
    parameter int              TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld_i,
    input  logic [DW-1:0]  data_i,
    input  logic [2:0]     key_index_i,
    input  logic [IDW-1:0] order_id_i,
    output logic           vld_o,
    output logic [DW-1:0]  data_o,
    output logic [IDW-1:0] id_o,
    output logic           tail_o,
    output logic           resync_o,
    output logic [15:0]    err_cnt_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic {
        RUN,
        RESYNC
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] exp_q, exp_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           vld_q, vld_d;
    logic [DW-1:0]  data_q, data_d;
    logic [IDW-1:0] id_q, id_d;
    logic           tail_q, tail_d;
    logic [15:0]    err_q, err_d;

    logic [DW-1:0]  key;
    logic           match;

    always_comb begin
        key = '0;
        if (key_index_i <= 3'd2) begin
            key = KEY;
        end
    end

    assign match = vld_i && (order_id_i == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        timer_d = timer_q;
        vld_d   = 1'b0;
        data_d  = data_q;
        id_d    = id_q;
        tail_d  = 1'b0;
        err_d   = err_q;

        // Accept path is shared by both states; a match always wins.
        if (match) begin
            vld_d   = 1'b1;
            data_d  = data_i ^ key;
            id_d    = order_id_i;
            exp_d   = exp_q + 1'b1;
            timer_d = '0;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (vld_i) begin
                        tail_d  = 1'b1;
                        state_d = RESYNC;
                        timer_d = '0;
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                    end
                end
                RESYNC: begin
                    // Retry: re-issue the resend request if the
                    // expected ID has not shown up in time.
                    if (timer_q == TMAX) begin
                        tail_d  = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            exp_q   <= '0;
            timer_q <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            tail_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            timer_q <= timer_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            id_q    <= id_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

    assign vld_o     = vld_q;
    assign data_o    = data_q;
    assign id_o      = id_q;
    assign tail_o    = tail_q;
    assign resync_o  = (state_q == RESYNC);
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_collect_rx.sv
// tb_collect_rx: table-driven bench for collect_rx with a
// queue of expected outputs checked one cycle after each drive.
module tb_collect_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_i;
    logic [31:0] data_i;
    logic [2:0]  key_index_i;
    logic [3:0]  order_id_i;
    logic        vld_o;
    logic [31:0] data_o;
    logic [3:0]  id_o;
    logic        tail_o;
    logic        resync_o;
    logic [15:0] err_cnt_o;

    always #5 clk = ~clk;

    collect_rx #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .vld_i       (vld_i),
        .data_i      (data_i),
        .key_index_i (key_index_i),
        .order_id_i  (order_id_i),
        .vld_o       (vld_o),
        .data_o      (data_o),
        .id_o        (id_o),
        .tail_o      (tail_o),
        .resync_o    (resync_o),
        .err_cnt_o   (err_cnt_o)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  key;
        logic [3:0]  id;
        logic [31:0] data;
        logic        e_vld;
        logic [31:0] e_data;
        logic [3:0]  e_id;
        logic        e_tail;
        logic        e_rs;
        logic [15:0] e_err;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] desc(logic [31:0] d, logic [2:0] k);
        return (k < 3'd3) ? (d ^ 32'h0000_FFFF) : d;
    endfunction

    function automatic vec_t mk(
        logic r, logic v, logic [2:0] k, logic [3:0] id, logic [31:0] d,
        logic ev, logic [31:0] ed, logic [3:0] eid,
        logic et, logic ers, logic [15:0] ee);
        vec_t x;
        x.rst = r; x.vld = v; x.key = k; x.id = id; x.data = d;
        x.e_vld = ev; x.e_data = ed; x.e_id = eid;
        x.e_tail = et; x.e_rs = ers; x.e_err = ee;
        return x;
    endfunction

    task automatic chk(string nm, int step, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int step);
        vec_t e;
        rst         = v.rst;
        vld_i       = v.vld;
        key_index_i = v.key;
        order_id_i  = v.id;
        data_i      = v.data;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard step %0d: got empty expected entry", step);
        end else begin
            e = sb.pop_front();
            chk("vld_o",     step, 32'(vld_o),     32'(e.e_vld));
            chk("data_o",    step, data_o,         e.e_data);
            chk("id_o",      step, 32'(id_o),      32'(e.e_id));
            chk("tail_o",    step, 32'(tail_o),    32'(e.e_tail));
            chk("resync_o",  step, 32'(resync_o),  32'(e.e_rs));
            chk("err_cnt_o", step, 32'(err_cnt_o), 32'(e.e_err));
        end
    endtask

    localparam logic [31:0] D0 = 32'h1234_5678;

    initial begin
        int st;
        logic [31:0] gd;
        rst = 1'b1; vld_i = 1'b0; data_i = '0;
        key_index_i = '0; order_id_i = '0;

        // Reset state
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, D0, 0, 0, 0, 0, 0, 0));
        // In-order stream with ID wrap
        for (int i = 0; i < 18; i++) begin
            vt.push_back(mk(0, 1, 0, 4'(i), D0,
                            1, 32'h1234_A987, 4'(i), 0, 0, 0));
        end
        // Idle: outputs hold
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h1234_A987, 4'd1, 0, 0, 0));
        // Pass-through key
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 5, 0, 32'hDEAD_BEEF,
                        1, 32'hDEAD_BEEF, 0, 0, 0, 0));
        // Gap and recovery: 0 1 3 4 2 3
        gd = 32'hA5A5_0000;
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 0, gd | 0, 1, desc(gd | 0, 1), 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 2, 1, gd | 1, 1, desc(gd | 1, 2), 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 3, gd | 3, 0, desc(gd | 1, 2), 1, 1, 1, 1));
        vt.push_back(mk(0, 1, 0, 4, gd | 4, 0, desc(gd | 1, 2), 1, 0, 1, 1));
        vt.push_back(mk(0, 1, 7, 2, gd | 2, 1, gd | 2, 2, 0, 0, 1));
        vt.push_back(mk(0, 1, 0, 3, gd | 3, 1, desc(gd | 3, 0), 3, 0, 0, 1));

        st = 0;
        foreach (vt[i]) begin
            apply(vt[i], st);
            st++;
        end

        // Timeout retry: bad ID 5 with exp_id 0, then idle
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), st++);
        apply(mk(0, 1, 0, 5, D0, 0, 0, 0, 1, 1, 1), st++);
        for (int k = 1; k <= 20; k++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0,
                     (k % 8) == 0, 1, 1), st++);
        end
        // Idle up to timer == TIMEOUT-1, then match on that cycle
        for (int k = 21; k <= 23; k++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), st++);
        end
        apply(mk(0, 1, 0, 0, D0, 1, 32'h1234_A987, 0, 0, 0, 1), st++);
        apply(mk(0, 0, 0, 0, 0, 0, 32'h1234_A987, 0, 0, 0, 1), st++);
        apply(mk(0, 1, 6, 1, D0, 1, D0, 1, 0, 0, 1), st++);

        // Reset mid-RESYNC, then ID 0
        apply(mk(0, 1, 0, 9, D0, 0, D0, 1, 1, 1, 2), st++);
        apply(mk(0, 0, 0, 0, 0, 0, D0, 1, 0, 1, 2), st++);
        apply(mk(1, 1, 0, 7, D0, 0, 0, 0, 0, 0, 0), st++);
        apply(mk(0, 1, 0, 0, D0, 1, 32'h1234_A987, 0, 0, 0, 0), st++);
        apply(mk(0, 0, 0, 0, 0, 0, 32'h1234_A987, 0, 0, 0, 0), st++);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
